// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
//   Read-side controller for a synchronous FIFO with 1-cycle read latency.
//   It pops words from the FIFO (rd_enb/empty/data_out) and presents them on
//   a valid/ready stream (m_valid/m_data/m_ready). A 2-entry output buffer
//   absorbs the read latency so back-to-back transfers run at 1 word/cycle.
//   A flush request discards the buffer, drains the FIFO and reports
//   completion with a single-cycle flush_done pulse.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   rd_enb      out  FIFO pop strobe (combinational, forced low during rst)
//   data_out    in   FIFO read data, valid the cycle after rd_enb
//   empty       in   FIFO empty flag
//   m_valid     out  stream valid (buffer not empty)
//   m_data      out  stream data (buffer head)
//   m_ready     in   downstream ready
//   flush       in   flush request, acted on only while running
//   flush_done  out  1-cycle pulse when the flush has completed
//   rd_cnt      out  count of accepted words, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rd_enb,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [CNT_W-1:0]      rd_cnt
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_buf_cnt;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic                  r_flush_done;
  logic [CNT_W-1:0]      r_rd_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_enb;
  logic                  w_flush_entry;
  logic                  w_flush_done_nxt;
  logic [2:0]            w_occ_after_pop;

  assign m_valid    = (r_buf_cnt != 2'd0);
  assign m_data     = r_buf0;
  assign flush_done = r_flush_done;
  assign rd_cnt     = r_rd_cnt;
  assign w_pop      = m_valid && m_ready;
  // A word requested last cycle lands on data_out now and is written this edge.
  assign w_push     = r_inflight;
  // The FIFO is reset together with us, so never strobe it while rst is high.
  assign rd_enb     = w_rd_enb && !rst;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, pop strobe and flush completion decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_rd_enb         = 1'b0;
    w_flush_entry    = 1'b0;
    w_flush_done_nxt = 1'b0;
    // Slots that stay committed after this cycle: buffered + in flight - leaving.
    w_occ_after_pop  = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    case (r_state)
      ST_RUN: begin
        w_rd_enb = !empty && (w_occ_after_pop < 3'd2);
        if (flush) begin
          w_state_nxt   = ST_FLUSH;
          w_flush_entry = 1'b1;
        end else begin
          w_state_nxt   = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_rd_enb = !empty;
        // Done only once the last requested word has come back and been dropped.
        if (empty && !r_inflight) begin
          w_state_nxt      = ST_RUN;
          w_flush_done_nxt = 1'b1;
        end else begin
          w_state_nxt      = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_rd_enb    = 1'b0;
      end
    endcase
  end

  // Read-latency tracking, completion pulse and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight   <= 1'b0;
      r_flush_done <= 1'b0;
      r_rd_cnt     <= '0;
    end else begin
      r_inflight   <= w_rd_enb;
      r_flush_done <= w_flush_done_nxt;
      if (w_pop) begin
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end else begin
        r_rd_cnt <= r_rd_cnt;
      end
    end
  end

  // Two-entry output buffer; r_buf0 is always the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_cnt <= 2'd0;
      r_buf0    <= '0;
      r_buf1    <= '0;
    end else if ((r_state == ST_FLUSH) || w_flush_entry) begin
      // Everything buffered or arriving while flushing is discarded.
      r_buf_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_buf_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= data_out;
          end else begin
            r_buf0 <= data_out;
          end
        end
        2'b10: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf0 <= data_out;
          end else begin
            r_buf1 <= data_out;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        default: begin
          r_buf_cnt <= r_buf_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//   Drives fifo_rd_ctrl from a queue-based FIFO model with 1-cycle read
//   latency, checks a cycle table, flush and reset sequences, and a random
//   stream against an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ctrl;
  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_enb;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          flush;
  logic          flush_done;
  logic [CW-1:0] rd_cnt;

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fifo_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_enb     (rd_enb),
    .data_out   (data_out),
    .empty      (empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .rd_cnt     (rd_cnt)
  );

  // Synchronous FIFO model: registered read data and registered empty flag.
  always @(posedge clk or posedge rst) begin : fifo_model
    int sz;
    if (rst) begin
      fifo_q.delete();
      data_out <= '0;
      empty    <= 1'b1;
    end else begin
      sz = fifo_q.size();
      if (rd_enb && sz > 0) data_out <= fifo_q.pop_front();
      if (wr_en && sz < DEPTH) fifo_q.push_back(wr_data);
      empty <= (fifo_q.size() == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          wr;
    logic [7:0]    wd;
    logic          mr;
    logic          rd;
    logic          mv;
    logic          chk_md;
    logic [7:0]    md;
    logic [15:0]   cnt;
  } vec_t;

  vec_t vt[25];

  task automatic setv(input int i, input logic wr, input logic [7:0] wd, input logic mr,
                      input logic rd, input logic mv, input logic cm, input logic [7:0] md,
                      input logic [15:0] cnt);
    vt[i] = '{wr, wd, mr, rd, mv, cm, md, cnt};
  endtask

  // Wait (bounded) for m_valid; returns at a negedge with ok set.
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;
    logic [DW-1:0] prev_data;
    bit            prev_hold;
    bit            ok;
    int            pulses;
    int            sent;
    int            got;
    int            issued;
    int            cyc;

    // T1 latency, T2 backpressure, T3 empty / single word (cumulative rd_cnt).
    //      i   wr    wd     mr    rd    mv    chk   md     cnt
    setv( 0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0);
    setv( 1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
    setv( 2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
    setv( 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0);
    setv( 4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 16'd1);
    setv( 5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd2);
    setv( 6, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd2);
    setv( 7, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd2);
    setv( 8, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd2);
    setv( 9, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16'd2);
    setv(10, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16'd2);
    setv(11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16'd2);
    setv(12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 16'd2);
    setv(13, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 16'd3);
    setv(14, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 16'd4);
    setv(15, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 16'd5);
    setv(16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 16'd6);
    setv(17, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd7);
    setv(18, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd7);
    setv(19, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd7);
    setv(20, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd7);
    setv(21, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd7);
    setv(22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd7);
    setv(23, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 16'd7);
    setv(24, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd8);

    // Reset state.
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_enb", rd_enb, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    tick();
    rst = 1'b0;

    // Table-driven cycles.
    for (int i = 0; i < 25; i++) begin
      wr_en = vt[i].wr; wr_data = vt[i].wd; m_ready = vt[i].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_enb", i), rd_enb, vt[i].rd);
      chk($sformatf("tbl%0d_m_valid", i), m_valid, vt[i].mv);
      if (vt[i].chk_md) chk($sformatf("tbl%0d_m_data", i), m_data, vt[i].md);
      chk($sformatf("tbl%0d_rd_cnt", i), rd_cnt, vt[i].cnt);
      chk($sformatf("tbl%0d_flush_done", i), flush_done, 0);
      tick();
    end
    wr_en = 1'b0;

    // T4 flush: 2 buffered + 8 in FIFO, then flush with m_ready low.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i);
      tick();
    end
    wr_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t4_pre_valid", m_valid, 1);
    chk("t4_pre_data", m_data, 8'h20);
    chk("t4_pre_fifo_level", fifo_q.size(), 8);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pulses = 0;
    @(negedge clk);
    chk("t4_valid_dropped", m_valid, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (flush_done) pulses++;
      tick();
    end
    chk("t4_done_pulses", pulses, 1);
    chk("t4_fifo_drained", fifo_q.size(), 0);
    chk("t4_rd_cnt_kept", rd_cnt, 8);
    chk("t4_valid_after", m_valid, 0);
    m_ready = 1'b1; wr_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    wait_valid(10, ok);
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL t4_post_timeout: got no m_valid expected word 11");
    end else begin
      chk("t4_post_data", m_data, 8'h11);
    end
    tick();
    @(negedge clk);
    chk("t4_post_rd_cnt", rd_cnt, 9);
    tick();

    // Handshake in the same cycle flush is sampled still counts.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    repeat (3) tick();
    flush = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk("t4b_flush_pop_valid", m_valid, 1);
    chk("t4b_flush_pop_data", m_data, 8'h31);
    tick();
    flush = 1'b0; m_ready = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (flush_done) pulses++;
      tick();
    end
    chk("t4b_done_pulses", pulses, 1);
    chk("t4b_rd_cnt", rd_cnt, 10);
    chk("t4b_valid", m_valid, 0);

    // T5 random concurrent stream against an in-order scoreboard.
    exp_q.delete();
    sent = 0; got = 0; issued = 0; prev_hold = 1'b0; prev_data = '0;
    for (cyc = 0; cyc < 3000 && got < 64; cyc++) begin
      wr_en   = (sent < 64) && (fifo_q.size() < DEPTH);
      wr_data = 8'($urandom);
      if (wr_en) begin
        exp_q.push_back(wr_data);
        sent++;
      end
      m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (rd_enb && empty) begin
        n_chk++; n_fail++;
        $display("FAIL t5_pop_empty: got rd_enb=1 expected 0 while empty");
      end
      chk("t5_occupancy_le2", (issued - got) <= 2, 1);
      if (prev_hold) begin
        chk("t5_hold_valid", m_valid, 1);
        chk("t5_hold_data", m_data, prev_data);
      end
      if (rd_enb && !empty) issued++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL t5_extra_word: got %0h expected none", m_data);
        end else begin
          exp_w = exp_q.pop_front();
          chk("t5_data", m_data, exp_w);
        end
        got++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      tick();
    end
    wr_en = 1'b0;
    if (got < 64) begin
      n_chk++; n_fail++;
      $display("FAIL t5_timeout: got %0d words expected 64", got);
    end
    @(negedge clk);
    chk("t5_rd_cnt", rd_cnt, 10 + 64);
    chk("t5_scoreboard_empty", exp_q.size(), 0);
    tick();

    // T6 reset mid-stream with a word in flight.
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hD0 + i);
      tick();
    end
    wr_en = 1'b1; wr_data = 8'hD3;
    @(negedge clk);
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_rd_enb", rd_enb, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_rd_enb", rd_enb, 0);
    chk("t6_rst_rd_cnt", rd_cnt, 0);
    chk("t6_rst_m_data", m_data, 0);
    wr_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hE1 + i);
      exp_q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        exp_w = exp_q.pop_front();
        chk("t6_data", m_data, exp_w);
        got++;
      end
      tick();
    end
    if (got < 3) begin
      n_chk++; n_fail++;
      $display("FAIL t6_timeout: got %0d words expected 3", got);
    end
    @(negedge clk);
    chk("t6_rd_cnt", rd_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
